// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard controller for the 5-stage WISC core.
// Decodes the instruction in ID and tracks the destinations of the instructions in EX and
// MEM. It raises a combinational stall on hazards that forwarding cannot cover, drops a
// bubble into EX, and registers the EX operand-forward selects.
//
// Build option: define HAZARD_FORWARD_EN to enable forwarding. Without it, the forward
// selects are tied to 0 and any RAW hazard against EX or MEM stalls.
//
// Parameters:
//   CNT_W  width of the saturating stall-cycle counter
//   REG_W  register specifier width (must match the 3-bit instruction fields)
// Ports:
//   i_clk          clock; all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_id_inst      instruction currently in ID
//   i_id_valid     i_id_inst is a real instruction (0 = bubble)
//   i_flush        taken branch/jump: kill the ID and EX entries
//   o_stall        combinational: hold PC and IF/ID, insert a bubble into EX
//   o_fwd_a_sel    registered EX operand A select: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   o_fwd_b_sel    registered EX operand B select, same encoding
//   o_stall_cnt    saturating count of cycles with o_stall=1
module hazard_scoreboard #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [15:0]      i_id_inst,
  input  logic             i_id_valid,
  input  logic             i_flush,
  output logic             o_stall,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [4:0]       w_op;
  logic [REG_W-1:0] w_src_a;
  logic [REG_W-1:0] w_src_b;
  logic [REG_W-1:0] w_dest;
  logic             w_use_a;
  logic             w_use_b;
  logic             w_has_dest;
  logic             w_bubble;
  logic             w_stall;
  logic             w_ex_a;
  logic             w_ex_b;
  logic             w_mem_a;
  logic             w_mem_b;
  logic             w_unused_func;

  // EX and MEM scoreboard entries. Once an entry moves on to WB the write-through regfile
  // already covers it, so WB needs no stored entry.
  logic             r_ex_v;
  logic [REG_W-1:0] r_ex_dest;
  logic             r_mem_v;
  logic [REG_W-1:0] r_mem_dest;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_op          = i_id_inst[15:11];
  assign w_src_a       = i_id_inst[10:8];
  assign w_src_b       = i_id_inst[7:5];
  assign w_unused_func = ^i_id_inst[1:0];

  // Source usage and destination decode
  always_comb begin
    w_use_a    = 1'b0;
    w_use_b    = 1'b0;
    w_has_dest = 1'b0;
    w_dest     = '0;
    casez (w_op)
      5'b11001, 5'b1101?, 5'b111??: begin
        w_use_a    = 1'b1;
        w_use_b    = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = i_id_inst[4:2];
      end
      5'b010??, 5'b101??, 5'b10001: begin
        w_use_a    = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = i_id_inst[7:5];
      end
      5'b10000: begin
        w_use_a = 1'b1;
        w_use_b = 1'b1;
      end
      5'b10011: begin
        w_use_a    = 1'b1;
        w_use_b    = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = i_id_inst[10:8];
      end
      5'b10010: begin
        w_use_a    = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = i_id_inst[10:8];
      end
      5'b11000: begin
        w_has_dest = 1'b1;
        w_dest     = i_id_inst[10:8];
      end
      5'b00111: begin
        w_use_a    = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = {REG_W{1'b1}};
      end
      5'b00110: begin
        w_has_dest = 1'b1;
        w_dest     = {REG_W{1'b1}};
      end
      5'b00101, 5'b011??: begin
        w_use_a = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_ex_a  = r_ex_v & (r_ex_dest == w_src_a);
  assign w_ex_b  = r_ex_v & (r_ex_dest == w_src_b);
  assign w_mem_a = r_mem_v & (r_mem_dest == w_src_a);
  assign w_mem_b = r_mem_v & (r_mem_dest == w_src_b);

`ifdef HAZARD_FORWARD_EN
  logic       w_is_ld;
  logic [1:0] w_fwd_a_d;
  logic [1:0] w_fwd_b_d;
  logic       r_ex_ld;
  logic [1:0] r_fwd_a_sel;
  logic [1:0] r_fwd_b_sel;

  assign w_is_ld = (w_op == 5'b10001);

  // Only a load still in EX cannot be forwarded; one bubble moves it to MEM.
  assign w_stall = i_id_valid & r_ex_ld & ((w_use_a & w_ex_a) | (w_use_b & w_ex_b));

  // EX is checked first so that the youngest writer wins.
  always_comb begin
    w_fwd_a_d = 2'd0;
    w_fwd_b_d = 2'd0;
    if (!w_bubble) begin
      if (w_use_a) begin
        if (w_ex_a && !r_ex_ld) w_fwd_a_d = 2'd1;
        else if (w_mem_a)       w_fwd_a_d = 2'd2;
      end
      if (w_use_b) begin
        if (w_ex_b && !r_ex_ld) w_fwd_b_d = 2'd1;
        else if (w_mem_b)       w_fwd_b_d = 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_ld     <= 1'b0;
      r_fwd_a_sel <= 2'd0;
      r_fwd_b_sel <= 2'd0;
    end else begin
      r_ex_ld     <= ~w_bubble & w_has_dest & w_is_ld;
      r_fwd_a_sel <= w_fwd_a_d;
      r_fwd_b_sel <= w_fwd_b_d;
    end
  end

  assign o_fwd_a_sel = r_fwd_a_sel;
  assign o_fwd_b_sel = r_fwd_b_sel;
`else
  // Without forwarding, ID waits until every producer has reached WB.
  assign w_stall = i_id_valid & ((w_use_a & (w_ex_a | w_mem_a)) | (w_use_b & (w_ex_b | w_mem_b)));

  assign o_fwd_a_sel = 2'd0;
  assign o_fwd_b_sel = 2'd0;
`endif

  // A flush kills the ID instruction even if it is also stalling.
  assign w_bubble = w_stall | i_flush | ~i_id_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_v      <= 1'b0;
      r_ex_dest   <= '0;
      r_mem_v     <= 1'b0;
      r_mem_dest  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_mem_v    <= r_ex_v;
      r_mem_dest <= r_ex_dest;
      r_ex_v     <= ~w_bubble & w_has_dest;
      r_ex_dest  <= w_bubble ? '0 : w_dest;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_stall_cnt = r_stall_cnt;

endmodule
